// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which requester owns the current transfer
//   BE_WORD     : full-word byte enable used for instruction fetches
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER_F = 2'd1,
        XFER_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_F = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arb_timeout.sv
// Wait-state watchdog for the memory bus arbiter.
// Loaded while clear is high; counts down once per enabled cycle and
// saturates at zero. expired is high when the current enabled cycle is the
// TIMEOUT_CYCLES-th consecutive wait cycle since the last clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : reload the counter (held while no transfer is on the bus)
//   enable     : one wait cycle elapsed
//   expired    : terminal count reached
module mem_arb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= LOAD;
        end else if (clear) begin
            remaining <= LOAD;
        end else if (enable && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign expired = (remaining == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single Avalon-MM master shared by instruction fetch and load/store data.
// One request is latched at a time; data wins over fetch when both are
// pending. Avalon strobes and payload are registered and held across
// waitrequest; the captured read word is returned with a one-cycle ack.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   defined   : a transfer stalled for TIMEOUT_CYCLES wait cycles is aborted
//               and acked with err = 1 (requester rdata left unchanged)
//   undefined : waits indefinitely, err tied to 0
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   f_req/f_addr -> f_ack/f_rdata     fetch read channel
//   d_req/d_we/d_addr/d_be/d_wdata    data channel request
//   d_ack/d_rdata                     data channel response
//   err                               pulses with the ack of an aborted transfer
//   busy                              high in every state except IDLE
//   avm_*                             Avalon-MM master port
//
// state  | meaning
// IDLE   | no transfer; sample d_req (priority) then f_req
// XFER_F | fetch read on the bus, waiting for waitrequest low
// XFER_D | data read/write on the bus, waiting for waitrequest low
// RESP   | one-cycle ack to the granted requester; requests ignored
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                f_req,
    input  logic [ADDR_W-1:0]   f_addr,
    output logic                f_ack,
    output logic [DATA_W-1:0]   f_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                err,
    output logic                busy,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
);

    localparam int unsigned BE_W = DATA_W / 8;

    // Fetch byte enables are built from whole-word groups, so DATA_W must be
    // a multiple of 32; a zero timeout would abort before the first wait.
    if ((DATA_W % 32 != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
        $error("mem_bus_arbiter: DATA_W must be a multiple of 32 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t        state_q, state_d;
    grant_t            grant_q, grant_d;
    logic [ADDR_W-1:0] address_d;
    logic [BE_W-1:0]   be_d;
    logic [DATA_W-1:0] wdata_d;
    logic              read_d, write_d;
    logic              f_ack_d, d_ack_d;
    logic [DATA_W-1:0] f_rdata_d, d_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    logic tmo_expired;
    logic in_xfer;
    logic err_d;

    assign in_xfer = (state_q == XFER_F) || (state_q == XFER_D);

    // Counter is held loaded outside XFER_*, so every transfer starts fresh.
    mem_arb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_xfer),
        .enable  (avm_waitrequest),
        .expired (tmo_expired)
    );
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        address_d = avm_address;
        be_d      = avm_byteenable;
        wdata_d   = avm_writedata;
        read_d    = avm_read;
        write_d   = avm_write;
        f_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        f_rdata_d = f_rdata;
        d_rdata_d = d_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
        err_d     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d   = XFER_D;
                    grant_d   = GNT_D;
                    address_d = d_addr;
                    be_d      = d_be;
                    wdata_d   = d_wdata;
                    read_d    = !d_we;
                    write_d   = d_we;
                end else if (f_req) begin
                    state_d   = XFER_F;
                    grant_d   = GNT_F;
                    address_d = f_addr;
                    be_d      = {(DATA_W / 32){BE_WORD}};
                    read_d    = 1'b1;
                    write_d   = 1'b0;
                end
            end

            XFER_F, XFER_D: begin
                if (!avm_waitrequest) begin
                    state_d = RESP;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (grant_q == GNT_D) begin
                        d_ack_d = 1'b1;
                        if (!avm_write) begin
                            d_rdata_d = avm_readdata;
                        end
                    end else begin
                        f_ack_d   = 1'b1;
                        f_rdata_d = avm_readdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (tmo_expired) begin
                    state_d = RESP;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    err_d   = 1'b1;
                    if (grant_q == GNT_D) begin
                        d_ack_d = 1'b1;
                    end else begin
                        f_ack_d = 1'b1;
                    end
                end
`endif
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            grant_q        <= GNT_F;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            f_ack          <= 1'b0;
            d_ack          <= 1'b0;
            f_rdata        <= '0;
            d_rdata        <= '0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            avm_address    <= address_d;
            avm_byteenable <= be_d;
            avm_writedata  <= wdata_d;
            avm_read       <= read_d;
            avm_write      <= write_d;
            f_ack          <= f_ack_d;
            d_ack          <= d_ack_d;
            f_rdata        <= f_rdata_d;
            d_rdata        <= d_rdata_d;
            busy           <= (state_d != IDLE);
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations plus a transaction-level reference model compared every cycle.
module tb_mem_bus_arbiter;

    localparam int TMO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req, f_ack;
    logic [31:0] f_addr, f_rdata;
    logic        d_req, d_we, d_ack;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        err, busy;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest;
    logic [3:0]  avm_byteenable;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int stall_target = 0;
    int stall_cnt = 0;

    mem_bus_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .f_req           (f_req),
        .f_addr          (f_addr),
        .f_ack           (f_ack),
        .f_rdata         (f_rdata),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_addr          (d_addr),
        .d_be            (d_be),
        .d_wdata         (d_wdata),
        .d_ack           (d_ack),
        .d_rdata         (d_rdata),
        .err             (err),
        .busy            (busy),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Avalon slave: stall_target wait cycles per access, then completes.
    always @(negedge clk) begin
        if (avm_read || avm_write) begin
            if (stall_cnt < stall_target) begin
                avm_waitrequest = 1'b1;
                stall_cnt++;
            end else begin
                avm_waitrequest = 1'b0;
            end
        end else begin
            avm_waitrequest = 1'b0;
            stall_cnt = 0;
        end
    end

    // Reference model: one outstanding transaction, acknowledged the cycle
    // after it leaves the bus; nothing new is accepted during that ack cycle.
    typedef struct packed {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } txn_t;

    txn_t        cur;
    bit          on_bus, acking;
    int          waited;
    logic        exp_f_ack, exp_d_ack, exp_err, exp_busy, exp_rd, exp_wr;
    logic [31:0] exp_f_rdata, exp_d_rdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_bus = 0; acking = 0; waited = 0; cur = '0;
            exp_f_ack = 0; exp_d_ack = 0; exp_err = 0; exp_busy = 0;
            exp_rd = 0; exp_wr = 0; exp_f_rdata = 0; exp_d_rdata = 0;
        end else begin
            exp_f_ack = 0; exp_d_ack = 0; exp_err = 0;
            if (acking) begin
                acking = 0;
            end else if (on_bus) begin
                if (!avm_waitrequest) begin
                    on_bus = 0; acking = 1;
                    if (cur.is_d) begin
                        exp_d_ack = 1;
                        if (!cur.we) exp_d_rdata = avm_readdata;
                    end else begin
                        exp_f_ack = 1;
                        exp_f_rdata = avm_readdata;
                    end
                end else begin
                    waited++;
                    if (TMO_EN && waited == TMO) begin
                        on_bus = 0; acking = 1; exp_err = 1;
                        if (cur.is_d) exp_d_ack = 1; else exp_f_ack = 1;
                    end
                end
            end else if (d_req) begin
                cur.is_d = 1; cur.we = d_we; cur.addr = d_addr; cur.be = d_be; cur.wdata = d_wdata;
                on_bus = 1; waited = 0;
            end else if (f_req) begin
                cur.is_d = 0; cur.we = 0; cur.addr = f_addr; cur.be = 4'hF;
                on_bus = 1; waited = 0;
            end
            exp_busy = on_bus || acking;
            exp_rd = on_bus && !cur.we;
            exp_wr = on_bus && cur.we;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("m_f_ack", 32'(f_ack), 32'(exp_f_ack));
            check("m_d_ack", 32'(d_ack), 32'(exp_d_ack));
            check("m_err", 32'(err), 32'(exp_err));
            check("m_busy", 32'(busy), 32'(exp_busy));
            check("m_avm_read", 32'(avm_read), 32'(exp_rd));
            check("m_avm_write", 32'(avm_write), 32'(exp_wr));
            check("m_f_rdata", f_rdata, exp_f_rdata);
            check("m_d_rdata", d_rdata, exp_d_rdata);
            if (exp_rd || exp_wr) begin
                check("m_avm_address", avm_address, cur.addr);
                check("m_avm_be", 32'(avm_byteenable), 32'(cur.be));
                if (exp_wr) check("m_avm_wdata", avm_writedata, cur.wdata);
            end
        end
    end

    task automatic wait_ack(input bit is_d, output int ack_cyc, output int first_strobe, output int n_strobe);
        ack_cyc = -1; first_strobe = -1; n_strobe = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (avm_read || avm_write) begin
                if (first_strobe < 0) first_strobe = cyc;
                n_strobe++;
            end
            if (is_d ? d_ack : f_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) check("ack_wait_expired", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, a1, a2, fs, ns;
        rst_n = 1'b0;
        f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_be = 0; d_wdata = 0;
        avm_readdata = 0; avm_waitrequest = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_avm_read", 32'(avm_read), 32'd0);
        check("rst_f_ack", 32'(f_ack), 32'd0);
        check("rst_avm_address", avm_address, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fetch read, no wait
        avm_readdata = 32'h24020005;
        t0 = cyc; f_addr = 32'hBFC00000; f_req = 1;
        wait_ack(0, a1, fs, ns);
        f_req = 0;
        check("t1_ack_latency", 32'(a1 - t0), 32'd2);
        check("t1_strobe_cycle", 32'(fs - t0), 32'd1);
        check("t1_f_rdata", f_rdata, 32'h24020005);
        repeat (2) @(negedge clk);

        // Store with 3 wait cycles
        stall_target = 3;
        t0 = cyc; d_we = 1; d_addr = 32'h1000; d_be = 4'b0011; d_wdata = 32'h0000BEEF; d_req = 1;
        wait_ack(1, a1, fs, ns);
        d_req = 0; d_we = 0;
        check("t2_ack_latency", 32'(a1 - t0), 32'd5);
        check("t2_strobe_cycles", 32'(ns), 32'd4);
        check("t2_d_rdata_kept", d_rdata, 32'd0);
        stall_target = 0;
        repeat (2) @(negedge clk);

        // Simultaneous data read and fetch
        avm_readdata = 32'h11223344;
        t0 = cyc; d_addr = 32'h2000; d_be = 4'hF; d_req = 1; f_addr = 32'h0400; f_req = 1;
        wait_ack(1, a1, fs, ns);
        d_req = 0;
        check("t3_d_first", 32'(a1 - t0), 32'd2);
        check("t3_d_rdata", d_rdata, 32'h11223344);
        avm_readdata = 32'h55667788;
        wait_ack(0, a2, fs, ns);
        f_req = 0;
        check("t3_f_strobe_after_d_ack", 32'(fs - a1), 32'd2);
        check("t3_f_ack_after_d_ack", 32'(a2 - a1), 32'd3);
        check("t3_f_rdata", f_rdata, 32'h55667788);
        repeat (2) @(negedge clk);

        // Fetch request held through its ack
        avm_readdata = 32'hA0A0A0A0;
        f_addr = 32'h0800; f_req = 1;
        wait_ack(0, a1, fs, ns);
        avm_readdata = 32'h0B0B0B0B;
        wait_ack(0, a2, fs, ns);
        f_req = 0;
        check("t6_ack_spacing", 32'(a2 - a1), 32'd3);
        check("t6_f_rdata", f_rdata, 32'h0B0B0B0B);
        repeat (2) @(negedge clk);

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout abort after TMO wait cycles
        stall_target = 100;
        avm_readdata = 32'hDEADDEAD;
        t0 = cyc; f_addr = 32'h0500; f_req = 1;
        wait_ack(0, a1, fs, ns);
        check("t5_err", 32'(err), 32'd1);
        f_req = 0;
        check("t5_ack_latency", 32'(a1 - t0), 32'd5);
        check("t5_strobe_cycles", 32'(ns), 32'd4);
        check("t5_f_rdata_kept", f_rdata, 32'h0B0B0B0B);
        stall_target = 0;
        repeat (2) @(negedge clk);
`endif

        // Reset during a waitrequest stall
        stall_target = 1000;
        f_addr = 32'h0300; f_req = 1;
        repeat (3) @(negedge clk);
        check("t4_pre_read", 32'(avm_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_avm_read", 32'(avm_read), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        f_req = 0;
        stall_target = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ns = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (f_ack || d_ack) ns++;
        end
        check("t4_no_ack", 32'(ns), 32'd0);
        check("t4_f_rdata_reset", f_rdata, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
